// File: rtl/stepmania_pkg.sv
// Shared lane geometry and judge result encoding for the note lanes,
// the LED driver and the score logic.
package stepmania_pkg;

  localparam int LANE_ROWS         = 8;
  localparam int LANE_SHIFT_PERIOD = 16;
  localparam int NUM_LANES         = 4;

  typedef enum logic [1:0] {
    JUDGE_NONE = 2'd0,
    JUDGE_HIT  = 2'd1,
    JUDGE_MISS = 2'd2
  } judge_e;

endpackage

// File: rtl/prompt_column_shift_tick.sv
// Free-running scroll-step divider; one instance per lane keeps all lanes
// phase-aligned through the shared reset.
module shift_tick #(
  parameter int SHIFT_PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (SHIFT_PERIOD > 1) ? $clog2(SHIFT_PERIOD) : 1;

  logic [CW-1:0] r_cnt;

  // SHIFT_PERIOD is a power of two, so natural overflow is the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CW'(SHIFT_PERIOD - 1));

endmodule

// File: rtl/prompt_column.sv
// One note lane: injects lit cells on start, scrolls them toward the judge
// cell and scores key presses against the bottom cell.
module prompt_column
  import stepmania_pkg::*;
#(
  parameter int ROWS         = LANE_ROWS,
  parameter int SHIFT_PERIOD = LANE_SHIFT_PERIOD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            key,
  output logic [ROWS-1:0] lights,
  output logic            hit,
  output logic            miss
);

  logic            w_tick;
  logic            w_press;
  logic            w_inj;
  logic            w_bottom;
  judge_e          w_judge;

  logic [ROWS-1:0] r_lights;
  logic            r_pending;
  logic            r_key_q;
  logic            r_hit;
  logic            r_miss;

  shift_tick #(
    .SHIFT_PERIOD(SHIFT_PERIOD)
  ) u_shift_tick (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  // A start landing on the tick cycle itself is injected with zero wait.
  assign w_inj    = r_pending | start;
  assign w_press  = key & ~r_key_q;
  assign w_bottom = r_lights[ROWS-1];

  always_comb begin
    w_judge = JUDGE_NONE;
    if (w_press) begin
      w_judge = w_bottom ? JUDGE_HIT : JUDGE_MISS;
    end else if (w_tick && w_bottom) begin
      w_judge = JUDGE_MISS;
    end
  end

  // key_q resets high so a key held through reset release is not a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lights  <= '0;
      r_pending <= 1'b0;
      r_key_q   <= 1'b1;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_key_q   <= key;
      r_pending <= w_tick ? 1'b0 : (r_pending | start);
      r_hit     <= (w_judge == JUDGE_HIT);
      r_miss    <= (w_judge == JUDGE_MISS);
      if (w_tick) begin
        r_lights <= {r_lights[ROWS-2:0], w_inj};
      end else if (w_judge == JUDGE_HIT) begin
        r_lights[ROWS-1] <= 1'b0;
      end
    end
  end

  assign lights = r_lights;
  assign hit    = r_hit;
  assign miss   = r_miss;

endmodule

// File: tb/tb_prompt_column.sv
// Bench for prompt_column: hand-computed vector table, directed held-key
// sequence and randomized traffic checked against a note-position model.
module tb_prompt_column;

  localparam int ROWS = 8;
  localparam int P    = 16;

  logic            clk;
  logic            reset;
  logic            start;
  logic            key;
  logic [ROWS-1:0] lights;
  logic            hit;
  logic            miss;

  int total = 0;
  int bad   = 0;

  prompt_column #(.ROWS(ROWS), .SHIFT_PERIOD(P)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .key   (key),
    .lights(lights),
    .hit   (hit),
    .miss  (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: notes are row positions; time is a cycle index since reset.
  int m_cnt;
  bit m_pending;
  bit m_keyq;
  bit m_hit;
  bit m_miss;
  int m_notes[$];

  function automatic logic [ROWS-1:0] model_lights();
    logic [ROWS-1:0] v;
    v = '0;
    foreach (m_notes[i]) v[m_notes[i]] = 1'b1;
    return v;
  endfunction

  function automatic void model_step(input bit r, input bit s, input bit k);
    bit tck, prs, bot;
    int nxt[$];
    if (r) begin
      m_cnt = 0; m_pending = 0; m_keyq = 1; m_hit = 0; m_miss = 0;
      m_notes.delete();
      return;
    end
    tck = (m_cnt == P - 1);
    prs = k && !m_keyq;
    bot = 0;
    foreach (m_notes[i]) if (m_notes[i] == ROWS - 1) bot = 1;
    m_hit  = prs && bot;
    m_miss = (prs && !bot) || (!prs && tck && bot);
    nxt.delete();
    foreach (m_notes[i]) begin
      if (m_notes[i] == ROWS - 1) begin
        if (!tck && !m_hit) nxt.push_back(m_notes[i]);
      end else begin
        nxt.push_back(tck ? m_notes[i] + 1 : m_notes[i]);
      end
    end
    if (tck && (m_pending || s)) nxt.push_back(0);
    m_notes   = nxt;
    m_pending = tck ? 0 : (m_pending || s);
    m_keyq    = k;
    m_cnt     = (m_cnt + 1) % P;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit k);
    reset = r; start = s; key = k;
    model_step(r, s, k);
    @(posedge clk);
    #1;
    chk("mdl_lights", 32'(lights), 32'(model_lights()));
    chk("mdl_hit",    32'(hit),    32'(m_hit));
    chk("mdl_miss",   32'(miss),   32'(m_miss));
  endtask

  typedef struct {
    bit          rst;
    bit          start;
    bit          key;
    int          reps;
    logic [7:0]  exp_lights;
    bit          exp_hit;
    bit          exp_miss;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit s, input bit k, input int n,
                              input logic [7:0] l, input bit h, input bit m);
    vec_t v;
    v.rst = r; v.start = s; v.key = k; v.reps = n;
    v.exp_lights = l; v.exp_hit = h; v.exp_miss = m;
    tbl.push_back(v);
  endfunction

  int  first_miss;
  int  n_miss;
  bit  rk;

  initial begin
    reset = 1'b1; start = 1'b0; key = 1'b0;

    // Comments give the cnt values covered by each row.
    add(1, 1, 1,   3, 8'h00, 0, 0);  // reset with start and key held
    add(0, 0, 1,  20, 8'h00, 0, 0);  // key held across release: no press
    add(0, 0, 0,   1, 8'h00, 0, 0);  // cnt 4
    add(0, 0, 1,   1, 8'h00, 0, 1);  // cnt 5 stray press
    add(0, 0, 1,   1, 8'h00, 0, 0);  // cnt 6 one-cycle pulse
    add(0, 1, 0,   1, 8'h00, 0, 0);  // cnt 7 start -> pending
    add(0, 1, 0,   1, 8'h00, 0, 0);  // cnt 8 second start same window
    add(0, 0, 0,   6, 8'h00, 0, 0);  // cnt 9..14
    add(0, 0, 0,   1, 8'h01, 0, 0);  // cnt 15 tick: single cell
    add(0, 0, 0, 112, 8'h80, 0, 0);  // seven ticks to judge row
    add(0, 0, 0,   6, 8'h80, 0, 0);  // cnt 0..5
    add(0, 0, 1,   1, 8'h00, 1, 0);  // cnt 6 hit mid-window
    add(0, 0, 1,   9, 8'h00, 0, 0);  // through tick: no miss
    add(0, 1, 0,   1, 8'h00, 0, 0);  // cnt 0 start
    add(0, 0, 0,  15, 8'h01, 0, 0);  // injected at cnt 15
    add(0, 0, 0, 112, 8'h80, 0, 0);
    add(0, 0, 0,  15, 8'h80, 0, 0);  // cnt 0..14
    add(0, 0, 0,   1, 8'h00, 0, 1);  // cnt 15 falls off
    add(0, 0, 0,   1, 8'h00, 0, 0);  // cnt 0
    add(0, 0, 0,  14, 8'h00, 0, 0);  // cnt 1..14
    add(0, 1, 0,   1, 8'h01, 0, 0);  // cnt 15 start: zero wait
    add(0, 0, 0, 112, 8'h80, 0, 0);
    add(0, 0, 0,  15, 8'h80, 0, 0);  // cnt 0..14
    add(0, 1, 1,   1, 8'h01, 1, 0);  // tick press + inject
    add(0, 0, 0,  20, 8'h02, 0, 0);  // next tick moves it
    add(1, 0, 0,   1, 8'h00, 0, 0);  // reset mid-travel
    add(0, 0, 0,  40, 8'h00, 0, 0);  // nothing reported afterwards

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].reps; j++) begin
        step(tbl[i].rst, tbl[i].start, tbl[i].key);
        if (tbl[i].rst || i == 1) begin
          chk($sformatf("v%0d_quiet", i), 32'({lights, hit, miss}), 32'(0));
        end
      end
      chk($sformatf("v%0d_lights", i), 32'(lights), 32'(tbl[i].exp_lights));
      chk($sformatf("v%0d_hit",    i), 32'(hit),    32'(tbl[i].exp_hit));
      chk($sformatf("v%0d_miss",   i), 32'(miss),   32'(tbl[i].exp_miss));
    end

    // Held key on an empty lane: exactly one miss, right after the rise.
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    first_miss = -1;
    n_miss = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1);
      if (miss) begin
        n_miss++;
        if (first_miss < 0) first_miss = i;
      end
    end
    chk("held_miss_count", 32'(n_miss), 32'(1));
    chk("held_miss_when",  32'(first_miss), 32'(0));
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 0, 1);
    chk("repress_miss", 32'(miss), 32'(1));

    // Randomized traffic against the model.
    rk = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) rk = ~rk;
      step(($urandom_range(599) == 0), ($urandom_range(11) == 0), rk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prompt_column.md
# prompt_column

One note lane of the game, directly downstream of the prompt generator. A one-cycle `start` request from the generator injects a lit cell at the top of an 8-cell lane. Lit cells scroll one row per shift tick toward the bottom. The player's key is judged against the bottom cell: a press while it is lit scores a hit, and a stray press or a note falling off unpressed scores a miss. Four instances, one per column, drive the LED lanes and the score logic.

## Interface
Parameters:
- `ROWS`, 8: cells per lane, minimum 2. `lights[0]` is the top cell; `lights[ROWS-1]` is the bottom (judge) cell.
- `SHIFT_PERIOD`, 16: clock cycles per scroll step. Must be a power of two, minimum 2.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle inject request from the prompt generator.
- `key`, in, 1: already-synchronized button level, 1 = pressed.
- `lights`, out, `ROWS`: lane cell state, registered.
- `hit`, out, 1: one-cycle pulse, correct press.
- `miss`, out, 1: one-cycle pulse, stray press or missed note.

## Operation
- **Tick counter:** `cnt` counts 0..`SHIFT_PERIOD`-1 and wraps. `tick` is high while `cnt == SHIFT_PERIOD-1`.
- **Pending latch:** `start` sets `pending`. `pending` clears on every `tick`. The value injected on a tick is `inj = pending | start`, so a start arriving on the tick cycle is injected on that same tick.
- **Edge detect:** `key_q` is the registered `key`. A press is `press = key & ~key_q`. A held key produces exactly one press.
- **Judge, evaluated each cycle on the pre-update `lights`:**
  - press and `lights[ROWS-1]` = 1: `hit` pulses. The bottom cell is cleared; if this is a tick cycle, it is shifted out instead.
  - press and `lights[ROWS-1]` = 0: `miss` pulses (stray press).
  - no press, tick, and `lights[ROWS-1]` = 1: `miss` pulses (note fell off).
  - otherwise neither output pulses.
  - `hit` and `miss` are mutually exclusive by construction.
- **Shift:** on tick, `lights <= {lights[ROWS-2:0], inj}`, with the MSB dropped.
- **Alignment:** with the generator sharing `reset`, its start pulse (one cycle after its counter reaches 62) lands on `cnt` = 15 and is injected with zero wait. `pending` covers any other phase.

## Timing
- **Reset values:** `cnt`=0, `pending`=0, `lights`=0, `hit`=0, `miss`=0, `key_q`=1. Because `key_q` resets to 1, a key held through reset release does not register as a press.
- A `start` asserted together with `reset` is discarded.
- **Inject latency:** a start in the cycle with `cnt`=k sets `lights[0]` at the clock edge ending the next tick cycle. That is `SHIFT_PERIOD-1-k` cycles after the start cycle, or 0 if k=`SHIFT_PERIOD`-1.
- **Travel time:** a cell reaches `lights[ROWS-1]` `ROWS-1` ticks after injection. It is then judgeable for one full `SHIFT_PERIOD` window, up to and including the next tick cycle.
- **Output latency:** `hit` and `miss` are registered and assert on the cycle after the press or fall-off cycle. Each is high for exactly one cycle.
- **Reset mid-operation:** takes effect at the next edge regardless of state. No hit or miss is reported for notes in flight.
- **Fully lit lane:** all cells shift normally; there is no saturation or merging.

## Structure
- Shared package `stepmania_pkg`:
  - `LANE_ROWS` = 8 and `LANE_SHIFT_PERIOD` = 16, used by this block and by the LED driver.
  - `NUM_LANES` = 4.
- Sub-module `shift_tick`:
  - Parameterized by `SHIFT_PERIOD`; ports `clk`, `reset`, `tick`.
  - One instance per lane, so the four lanes stay phase-aligned through the common reset.
- The pending latch, edge detect, judge and shift register live in the top module.

## Test plan
1. **Reset:** hold `reset` for 3 cycles with `start`=1 and `key`=1, then release with `key` still held. Expect `lights`=0, `hit`=`miss`=0 throughout and for 20 cycles after release.
2. **Inject on tick and fall-off:**
   - Pulse `start` at `cnt`=15. Expect `lights`=8'b0000_0001 the next cycle.
   - After 112 more cycles, expect `lights`=8'b1000_0000.
   - At the following tick, with no key, expect `miss`=1 for one cycle and `lights`=0.
3. **Pending:** pulse `start` at `cnt`=3. Expect `lights` to stay 0 until the edge after `cnt`=15, then 8'b0000_0001. A second start at `cnt`=5 in the same window still yields a single cell.
4. **Hit mid-window:**
   - With `lights[7]`=1, press at `cnt`=6. Expect `hit`=1 one cycle later and `lights[7]`=0.
   - Expect no `miss` at the next tick.
5. **Stray and held press:**
   - With `lights`=0, hold `key` high for 40 cycles. Expect exactly one `miss` pulse, one cycle after the rising edge.
   - Release and press again. Expect a second `miss`.
6. **Press on tick with simultaneous inject:**
   - With `lights`=8'b1000_0000, press on a tick cycle while `start`=1. Expect `hit`=1 only, no `miss`, and `lights`=8'b0000_0001.
   - Then assert `reset` mid-travel. Expect `lights`=0 at the next edge and no pulses.
